axis_packet_fifo: RTL and testbench

Synchronous AXI4-Stream FIFO placed directly downstream of an AXI-Stream master and upstream of any AXI-Stream slave. It is the standard DUT that the axis agent drives on its slave side and monitors on its master side. It buffers complete beats, including all sideband fields. An optional packet mode holds output until a whole packet (TLAST) is stored.

---
 rtl/axis_fifo_pkg.sv | 43 ++++
 rtl/axis_fifo_ram.sv | 43 ++++
 rtl/axis_packet_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_axis_packet_fifo.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream packet FIFO.
// Packet mode is selected with the AXIS_FIFO_PACKET_MODE_EN macro.
package axis_fifo_pkg;

    // Default payload widths, matching the default FIFO configuration
    localparam int unsigned AXIS_DATA_W_DFLT = 32;
    localparam int unsigned AXIS_ID_W_DFLT   = 8;
    localparam int unsigned AXIS_DEST_W_DFLT = 4;
    localparam int unsigned AXIS_USER_W_DFLT = 1;
    localparam int unsigned AXIS_KS_W_DFLT   = AXIS_DATA_W_DFLT / 8;

    // One stored beat at the default widths; the FIFO top builds the same
    // field layout from its own parameters so that any width set is legal.
    typedef struct packed {
        logic [AXIS_DATA_W_DFLT-1:0] tdata;
        logic [AXIS_KS_W_DFLT-1:0]   tstrb;
        logic [AXIS_KS_W_DFLT-1:0]   tkeep;
        logic [AXIS_ID_W_DFLT-1:0]   tid;
        logic [AXIS_DEST_W_DFLT-1:0] tdest;
        logic [AXIS_USER_W_DFLT-1:0] tuser;
        logic                        tlast;
    } axis_beat_t;

    // Packet-mode output gating states
    typedef enum logic {
        STORE   = 1'b0,
        FORWARD = 1'b1
    } pkt_state_e;

    // Bits needed to hold a count from 0 to depth inclusive
    function automatic int unsigned clog2_level(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Total packed width of one beat for a given set of field widths
    function automatic int unsigned beat_width(input int unsigned data_w,
                                               input int unsigned id_w,
                                               input int unsigned dest_w,
                                               input int unsigned user_w);
        return data_w + 2 * (data_w / 8) + id_w + dest_w + user_w + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Beat storage: DEPTH x WIDTH register array, one write and one read port.
// Read data is registered; a same-cycle write to the addressed entry is
// forwarded so a freshly pushed beat is visible on the next cycle.
module axis_fifo_ram #(
    parameter int unsigned WIDTH  = 54,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Storage array write, no reset needed
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read mux with write-through forwarding on address match
    always_comb begin
        rd_data_d = mem_q[rd_addr_i];
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = wr_data_i;
        end
    end

    // Registered read port
    always_ff @(posedge clk_i) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_packet_fifo.sv
// Synchronous AXI4-Stream FIFO buffering full beats with all sideband fields.
// Define AXIS_FIFO_PACKET_MODE_EN to build packet mode: output is withheld
// until a complete packet (TLAST) is stored, with a FORWARD escape when an
// oversize packet fills the FIFO.
module axis_packet_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned USER_W = 1,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    // slave side
    input  logic                          S_TVALID,
    output logic                          S_TREADY,
    input  logic                          S_TLAST,
    input  logic [DATA_W-1:0]             S_TDATA,
    input  logic [DATA_W/8-1:0]           S_TSTRB,
    input  logic [DATA_W/8-1:0]           S_TKEEP,
    input  logic [ID_W-1:0]               S_TID,
    input  logic [DEST_W-1:0]             S_TDEST,
    input  logic [USER_W-1:0]             S_TUSER,
    // master side
    output logic                          M_TVALID,
    input  logic                          M_TREADY,
    output logic                          M_TLAST,
    output logic [DATA_W-1:0]             M_TDATA,
    output logic [DATA_W/8-1:0]           M_TSTRB,
    output logic [DATA_W/8-1:0]           M_TKEEP,
    output logic [ID_W-1:0]               M_TID,
    output logic [DEST_W-1:0]             M_TDEST,
    output logic [USER_W-1:0]             M_TUSER,
    // status
    output logic [clog2_level(DEPTH)-1:0] LEVEL,
    output logic [clog2_level(DEPTH)-1:0] PKT_CNT
);

    localparam int unsigned KEEP_STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned LVL_W       = clog2_level(DEPTH);
    localparam int unsigned BEAT_W      = beat_width(DATA_W, ID_W, DEST_W, USER_W);

    typedef struct packed {
        logic [DATA_W-1:0]      tdata;
        logic [KEEP_STRB_W-1:0] tstrb;
        logic [KEEP_STRB_W-1:0] tkeep;
        logic [ID_W-1:0]        tid;
        logic [DEST_W-1:0]      tdest;
        logic [USER_W-1:0]      tuser;
        logic                   tlast;
    } beat_t;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, full_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              push_c, pop_c;
    beat_t             s_beat;
    beat_t             m_beat;
    logic [BEAT_W-1:0] s_beat_raw;
    logic [BEAT_W-1:0] m_beat_raw;

    // Handshakes
    assign push_c = S_TVALID & S_TREADY;
    assign pop_c  = M_TVALID & M_TREADY;

    // Pack the incoming beat
    always_comb begin
        s_beat       = '0;
        s_beat.tdata = S_TDATA;
        s_beat.tstrb = S_TSTRB;
        s_beat.tkeep = S_TKEEP;
        s_beat.tid   = S_TID;
        s_beat.tdest = S_TDEST;
        s_beat.tuser = S_TUSER;
        s_beat.tlast = S_TLAST;
    end

    assign s_beat_raw = BEAT_W'(s_beat);

    // Read address is the next read pointer so the head is always preloaded
    axis_fifo_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (ACLK),
        .wr_en_i   (push_c),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (s_beat_raw),
        .rd_addr_i (rd_ptr_d),
        .rd_data_o (m_beat_raw)
    );

    assign m_beat = beat_t'(m_beat_raw);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_W'(DEPTH));
    end

    // Pointer, occupancy and output-valid registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    pkt_state_e       state_q, state_d;
    logic [LVL_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Packet counter, STORE/FORWARD transitions and gated output valid
    always_comb begin
        state_d    = state_q;
        pkt_cnt_d  = pkt_cnt_q;
        m_tvalid_d = 1'b0;
        case ({push_c & S_TLAST, pop_c & m_beat.tlast})
            2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        case (state_q)
            STORE: begin
                // Full with no complete packet: forward to avoid deadlock
                if ((level_q == LVL_W'(DEPTH)) && (pkt_cnt_q == '0)) begin
                    state_d = FORWARD;
                end
            end
            FORWARD: begin
                if (pop_c && m_beat.tlast) begin
                    state_d = STORE;
                end
            end
            default: state_d = STORE;
        endcase
        m_tvalid_d = (level_d != '0) && ((state_d == FORWARD) || (pkt_cnt_d != '0));
    end

    // Packet-mode state registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= STORE;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign PKT_CNT = pkt_cnt_q;
`else
    // Plain beat FIFO: valid whenever anything is stored
    always_comb begin
        m_tvalid_d = (level_d != '0);
    end

    assign PKT_CNT = '0;
`endif

    // Output drive
    assign S_TREADY = ~ARESET & ~full_q;
    assign M_TVALID = m_tvalid_q;
    assign M_TDATA  = m_beat.tdata;
    assign M_TSTRB  = m_beat.tstrb;
    assign M_TKEEP  = m_beat.tkeep;
    assign M_TID    = m_beat.tid;
    assign M_TDEST  = m_beat.tdest;
    assign M_TUSER  = m_beat.tuser;
    assign M_TLAST  = m_beat.tlast;
    assign LEVEL    = level_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo: queue scoreboard fed on
// accepted input beats, output monitor checking every cycle.
module tb_axis_packet_fifo;

    localparam int unsigned DEPTH = 16;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    localparam bit PKT_MODE = 1'b1;
`else
    localparam bit PKT_MODE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [7:0]  id;
        logic [3:0]  dest;
        logic [0:0]  user;
        logic        last;
    } beat_t;

    logic        ACLK;
    logic        ARESET;
    logic        S_TVALID, S_TREADY, S_TLAST;
    logic [31:0] S_TDATA;
    logic [3:0]  S_TSTRB, S_TKEEP;
    logic [7:0]  S_TID;
    logic [3:0]  S_TDEST;
    logic [0:0]  S_TUSER;
    logic        M_TVALID, M_TREADY, M_TLAST;
    logic [31:0] M_TDATA;
    logic [3:0]  M_TSTRB, M_TKEEP;
    logic [7:0]  M_TID;
    logic [3:0]  M_TDEST;
    logic [0:0]  M_TUSER;
    logic [4:0]  LEVEL, PKT_CNT;

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;   // 0 hold low, 1 always high, 2 random, 3 manual

    beat_t sb[$];
    bit    fwd = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_out;

    axis_packet_fifo #(
        .DATA_W (32), .ID_W (8), .DEST_W (4), .USER_W (1), .DEPTH (DEPTH)
    ) dut (
        .ACLK     (ACLK),     .ARESET   (ARESET),
        .S_TVALID (S_TVALID), .S_TREADY (S_TREADY), .S_TLAST (S_TLAST),
        .S_TDATA  (S_TDATA),  .S_TSTRB  (S_TSTRB),  .S_TKEEP (S_TKEEP),
        .S_TID    (S_TID),    .S_TDEST  (S_TDEST),  .S_TUSER (S_TUSER),
        .M_TVALID (M_TVALID), .M_TREADY (M_TREADY), .M_TLAST (M_TLAST),
        .M_TDATA  (M_TDATA),  .M_TSTRB  (M_TSTRB),  .M_TKEEP (M_TKEEP),
        .M_TID    (M_TID),    .M_TDEST  (M_TDEST),  .M_TUSER (M_TUSER),
        .LEVEL    (LEVEL),    .PKT_CNT  (PKT_CNT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor and reference model, sampled on the falling edge
    always @(negedge ACLK) begin
        beat_t cin, cout;
        int    lastcnt;
        bit    exp_v, push, pop;
        cin  = '{S_TDATA, S_TSTRB, S_TKEEP, S_TID, S_TDEST, S_TUSER, S_TLAST};
        cout = '{M_TDATA, M_TSTRB, M_TKEEP, M_TID, M_TDEST, M_TUSER, M_TLAST};
        if (ARESET === 1'b1) begin
            chk("tready_in_reset", 64'(S_TREADY), 64'(0));
            sb.delete();
            fwd        = 1'b0;
            prev_stall = 1'b0;
        end else begin
            lastcnt = 0;
            foreach (sb[i]) if (sb[i].last) lastcnt++;
            exp_v = (sb.size() > 0) && (!PKT_MODE || lastcnt > 0 || fwd);
            chk("level", 64'(LEVEL), 64'(sb.size()));
            chk("pkt_cnt", 64'(PKT_CNT), PKT_MODE ? 64'(lastcnt) : 64'(0));
            chk("s_tready", 64'(S_TREADY), 64'(sb.size() != DEPTH));
            chk("m_tvalid", 64'(M_TVALID), 64'(exp_v));
            if (prev_stall) begin
                chk("valid_hold", 64'(M_TVALID), 64'(1));
                chk("payload_hold", 64'(cout), 64'(prev_out));
            end
            if (M_TVALID === 1'b1 && sb.size() > 0) begin
                chk("payload", 64'(cout), 64'(sb[0]));
            end
            push = (S_TVALID === 1'b1) && (S_TREADY === 1'b1);
            pop  = (M_TVALID === 1'b1) && (M_TREADY === 1'b1);
            if (PKT_MODE) begin
                if (!fwd && sb.size() == DEPTH && lastcnt == 0) fwd = 1'b1;
                else if (fwd && pop && sb.size() > 0 && sb[0].last) fwd = 1'b0;
            end
            if (pop && sb.size() > 0) void'(sb.pop_front());
            if (push) sb.push_back(cin);
            prev_stall = (M_TVALID === 1'b1) && (M_TREADY !== 1'b1);
            prev_out   = cout;
        end
    end

    // Sink-side ready generator
    initial begin
        M_TREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            case (rdy_mode)
                0:       M_TREADY = 1'b0;
                1:       M_TREADY = 1'b1;
                2:       M_TREADY = 1'($urandom_range(1));
                default: ;
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic drive(input beat_t b);
        S_TDATA = b.data; S_TSTRB = b.strb; S_TKEEP = b.keep;
        S_TID   = b.id;   S_TDEST = b.dest; S_TUSER = b.user; S_TLAST = b.last;
    endtask

    function automatic beat_t rnd_beat(input bit last);
        beat_t b;
        b.data = $urandom();
        b.strb = 4'($urandom());
        b.keep = 4'($urandom());
        b.id   = 8'($urandom());
        b.dest = 4'($urandom());
        b.user = 1'($urandom());
        b.last = last;
        return b;
    endfunction

    // Present one beat and hold it until accepted (bounded)
    task automatic send_beat(input beat_t b);
        bit acc = 1'b0;
        int waited = 0;
        drive(b);
        S_TVALID = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge ACLK);
            acc = (S_TREADY === 1'b1);
            waited++;
            @(posedge ACLK);
            #1;
        end
        S_TVALID = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat 0x%0h not accepted, required within 200 cycles", b.data);
        end
    endtask

    // Let the sink take everything stored (bounded)
    task automatic drain();
        int n = 0;
        rdy_mode = 1;
        while (sb.size() != 0 && n < 500) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        beat_t b;
        int    nbeats;
        ARESET   = 1'b1;
        S_TVALID = 1'b0;
        drive('0);
        cyc(3);
        ARESET = 1'b0;
        cyc(2);

        // four in-order beats with the sink always ready
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            b = rnd_beat(i == 3);
            b.data = 32'h11 * 32'(i + 1);
            send_beat(b);
        end
        drain();

        // fill to DEPTH, attempt one more, then a single pop
        rdy_mode = 3;
        M_TREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_beat(rnd_beat(1'b1));
        b = rnd_beat(1'b1);
        drive(b);
        S_TVALID = 1'b1;
        cyc(3);
        chk("full_level", 64'(LEVEL), 64'(DEPTH));
        M_TREADY = 1'b1;
        cyc(1);
        M_TREADY = 1'b0;
        send_beat(b);
        cyc(2);
        drain();

        // randomized stream with random source gaps and sink backpressure
        rdy_mode = 2;
        nbeats = 1000;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(1) == 0) cyc(1);
            send_beat(rnd_beat((i == nbeats - 1) || ($urandom_range(3) == 0)));
        end
        drain();

        // 5-beat packet, TLAST on the fifth beat
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) send_beat(rnd_beat(i == 4));
        drain();

        // 20-beat packet, longer than the FIFO
        for (int i = 0; i < 20; i++) send_beat(rnd_beat(i == 19));
        drain();

        // reset with 7 beats of an unfinished packet stored
        rdy_mode = 0;
        cyc(1);
        for (int i = 0; i < 7; i++) send_beat(rnd_beat(1'b0));
        cyc(1);
        chk("pre_reset_level", 64'(LEVEL), 64'(7));
        ARESET = 1'b1;
        cyc(1);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_reset_valid", 64'(M_TVALID), 64'(0));
        chk("post_reset_level", 64'(LEVEL), 64'(0));
        chk("post_reset_pkt", 64'(PKT_CNT), 64'(0));
        @(posedge ACLK);
        #1;
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) send_beat(rnd_beat(i == 2));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
